// File: rtl/branch_train_unit_pkg.sv
// rtl/branch_train_unit_pkg.sv - shared constants and record type for the branch training unit
package branch_train_unit_pkg;

  // Default number of queued training records
  localparam int TRAIN_DEPTH_DEFAULT = 4;

  // Fall-through step for a not-taken branch
  localparam logic [31:0] INSTR_STEP = 32'd4;

  // Training record: branch PC plus actual direction
  localparam int TRAIN_REC_W = 33;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } train_rec_t;

  // Corrected fetch PC after a wrong-direction prediction
  function automatic logic [31:0] redirect_pc(input logic        taken,
                                              input logic [31:0] pc,
                                              input logic [31:0] target);
    return taken ? target : (pc + INSTR_STEP);
  endfunction

endpackage

// File: rtl/branch_train_unit_train_fifo.sv
// rtl/branch_train_unit_train_fifo.sv - circular training-record FIFO with clear
module train_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // Guard against overflow/underflow regardless of what the caller asks
  always_comb begin
    full_o  = (count_q == FULL_CNT);
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    head_o  = mem_q[rd_ptr_q];
  end

  // Storage, pointers and occupancy; clear beats any same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/branch_train_unit.sv
// rtl/branch_train_unit.sv - resolved-branch intake, mispredict redirect and predictor training drain
module branch_train_unit
  import branch_train_unit_pkg::*;
#(
  parameter int DEPTH = TRAIN_DEPTH_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             Br_Valid,
  output logic             Br_Ready,
  input  logic [31:0]      Br_PC,
  input  logic             Br_Taken,
  input  logic [31:0]      Br_Target,
  input  logic             Br_Pred_Taken,
  input  logic             Clear,
  output logic             Train_Ready,
  output logic             Train_Result,
  output logic [31:0]      Name,
  input  logic             Train_Accept,
  output logic             Mispredict,
  output logic [31:0]      Redirect_PC,
  output logic [CNT_W-1:0] Br_Count,
  output logic [CNT_W-1:0] Miss_Count
);

  logic             acc, pop, clr, miss, fifo_full, fifo_empty;
  train_rec_t       push_rec, head_rec;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  // Handshakes, all qualified by the global ready
  always_comb begin
    Br_Ready    = !fifo_full;
    Train_Ready = !fifo_empty;
    acc         = Br_Valid && Br_Ready && rdy;
    pop         = Train_Ready && Train_Accept && rdy;
    clr         = Clear && rdy;
    miss        = acc && (Br_Taken != Br_Pred_Taken);
    push_rec    = '{pc: Br_PC, taken: Br_Taken};
  end

  train_fifo #(
    .DEPTH (DEPTH),
    .W     (TRAIN_REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (acc),
    .pop_i   (pop),
    .clear_i (clr),
    .wdata_i (push_rec),
    .head_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state for redirect and statistics; rdy low holds everything, which
  // also stretches a pending mispredict pulse until rdy returns
  always_comb begin
    mispredict_d = mispredict_q;
    redirect_d   = redirect_q;
    br_cnt_d     = br_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (rdy) begin
      mispredict_d = miss;
      if (miss) begin
        redirect_d = redirect_pc(Br_Taken, Br_PC, Br_Target);
        miss_cnt_d = miss_cnt_q + 1'b1;
      end
      if (acc) br_cnt_d = br_cnt_q + 1'b1;
    end
  end

  // Redirect and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Output mapping
  always_comb begin
    Train_Result = head_rec.taken;
    Name         = head_rec.pc;
    Mispredict   = mispredict_q;
    Redirect_PC  = redirect_q;
    Br_Count     = br_cnt_q;
    Miss_Count   = miss_cnt_q;
  end

endmodule

// File: doc/branch_train_unit.md
# branch_train_unit

Producer side of the predictor training interface. Accepts resolved conditional branches from the branch ALU, and signals a mispredict with the corrected fetch PC one cycle later. Buffers each outcome in a small FIFO and drains it to the branch predictor's `Train_Ready` / `Train_Result` / `Name` port, one record per accepted handshake. Keeps running branch and mispredict counters for performance checks.

## Interface

Parameters:
- `DEPTH`, default 4: training FIFO entries, power of two, at least 2.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global ready; low freezes all state.
- `Br_Valid`  in  1  resolved branch presented by the ALU.
- `Br_Ready`  out  1  unit can accept a branch this cycle.
- `Br_PC`  in  32  PC of the branch.
- `Br_Taken`  in  1  actual outcome.
- `Br_Target`  in  32  taken target, PC+Imm.
- `Br_Pred_Taken`  in  1  direction predicted at fetch.
- `Clear`  in  1  drop all queued training records (wrong-path flush).
- `Train_Ready`  out  1  training record valid, to the predictor.
- `Train_Result`  out  1  outcome of the head record.
- `Name`  out  32  branch PC of the head record.
- `Train_Accept`  in  1  predictor consumes the head record.
- `Mispredict`  out  1  redirect request to fetcher and ROB.
- `Redirect_PC`  out  32  corrected fetch PC.
- `Br_Count`  out  `CNT_W`  branches accepted.
- `Miss_Count`  out  `CNT_W`  mispredicts detected.

## Operation

- Accept: `acc = Br_Valid && Br_Ready && rdy`. `Br_Ready = (count != DEPTH)`. This is combinational from registered state only.
- On `acc`:
  - push {`Br_PC`, `Br_Taken`} into the FIFO;
  - increment `Br_Count`;
  - if `Br_Taken != Br_Pred_Taken`, increment `Miss_Count` and schedule a mispredict.
- Mispredict output:
  - registered; `Mispredict` = 1 in the cycle after `acc` with a wrong direction, otherwise 0;
  - `Redirect_PC = Br_Taken ? Br_Target : Br_PC + 4`, arithmetic mod 2^32. It is updated only when `Mispredict` is set and holds its value otherwise.
- Drain:
  - `Train_Ready = (count != 0)`; `Train_Result` and `Name` come from the FIFO head.
  - Pop when `Train_Ready && Train_Accept && rdy`.
  - `Train_Result` and `Name` are don't-care when `Train_Ready` = 0. The bench must not check them then.
- FIFO:
  - circular; read and write pointers are `$clog2(DEPTH)` bits and wrap naturally;
  - `count` is `$clog2(DEPTH)+1` bits.
- Push and pop in the same cycle: both occur and `count` is unchanged. Allowed even when `count == DEPTH`? No: `Br_Ready` is 0 then, so only the pop occurs.
- `Clear` (sampled when `rdy`):
  - empties the FIFO (pointers and count to 0) and wins over a same-cycle push or pop; the pushed record is discarded;
  - the counters and mispredict detection for a same-cycle `acc` still take effect;
  - counters are never cleared except by reset.
- Counters wrap modulo 2^`CNT_W`.
- `rdy` = 0:
  - no push, pop, or counter change;
  - `Mispredict` and all other outputs hold their values;
  - a pending `Mispredict` pulse is extended until the first `rdy` = 1 cycle, then deasserted.

## Timing

- Reset (`rst` low, asynchronous): FIFO empty; `Train_Ready` = 0, `Br_Ready` = 1, `Mispredict` = 0, `Redirect_PC` = 0, `Name` = 0, `Train_Result` = 0, `Br_Count` = 0, `Miss_Count` = 0.
- Reset asserted mid-operation discards all queued records immediately. Deassertion is synchronous to `clk`, handled by the standard reset synchronizer outside this block.
- Branch accepted at edge N:
  - the record is visible at the FIFO head (if the FIFO was empty) after edge N, i.e. `Train_Ready` = 1 in cycle N+1;
  - `Mispredict` is valid in the same cycle N+1.
- Throughput: one accept and one drain per cycle sustained.
- Mispredicts on consecutive cycles produce back-to-back `Mispredict` = 1 cycles, each with its own `Redirect_PC`.

## Structure

- Shared `constants.v`:
  - default `DEPTH`;
  - the instruction step constant (4) used for fall-through;
  - the training record width (33).
- Sub-module `train_fifo`: parameterized circular FIFO with push, pop, clear, full, empty and head outputs. The mispredict and counter logic stay in `branch_train_unit`.

## Test plan

- Reset then idle:
  - all outputs at reset values;
  - `Br_Ready` = 1, `Train_Ready` = 0 for 10 cycles.
- Correct prediction:
  - stimulus: `Br_PC` = 0x100, `Br_Taken` = 1, `Br_Pred_Taken` = 1, `Br_Target` = 0x140;
  - next cycle: `Train_Ready` = 1, `Name` = 0x100, `Train_Result` = 1, `Mispredict` = 0;
  - counters: `Br_Count` = 1, `Miss_Count` = 0.
- Mispredict, not-taken predicted taken:
  - stimulus: `Br_PC` = 0x200, `Br_Taken` = 0, `Br_Pred_Taken` = 1;
  - next cycle: `Mispredict` = 1, `Redirect_PC` = 0x204; the cycle after, `Mispredict` = 0.
  - Taken case: `Br_Taken` = 1, `Br_Target` = 0x80 gives `Redirect_PC` = 0x80.
  - `Br_PC` = 0xFFFFFFFC not-taken mispredict gives `Redirect_PC` = 0x00000000.
- Full / backpressure:
  - with `Train_Accept` = 0, push 4 branches; `Br_Ready` = 0 and the 5th `Br_Valid` is ignored (`Br_Count` stays 4);
  - then `Train_Accept` = 1 drains in order 0x10, 0x20, 0x30, 0x40;
  - simultaneous push and pop at count 3 keeps count 3.
- `Clear` and `rdy`:
  - `Clear` with 3 queued plus a same-cycle push leaves `Train_Ready` = 0 next cycle; `Br_Count` still increments.
  - `rdy` = 0 for 3 cycles during a `Mispredict` pulse holds `Mispredict` = 1 and freezes the FIFO.
- Async reset mid-stream: `rst` low between clock edges with 2 records queued makes `Train_Ready` = 0 and zeroes the counters without waiting for a clock edge.
